// File: rtl/sha3_pkg.sv
// Shared SHA-3 types and constants for the digest output path.
package sha3_pkg;
  localparam int LANE_W          = 64;
  localparam int DIGEST_LANES    = 4;
  localparam int FINAL_ROUND_BIT = 23;
  localparam int ROUND_W         = 24;

  typedef logic [4:0][4:0][LANE_W-1:0]       sha3_state_t;
  typedef logic [DIGEST_LANES-1:0][LANE_W-1:0] sha3_digest_t;
  typedef logic [1:0]                        lane_idx_t;

  localparam lane_idx_t LAST_LANE = lane_idx_t'(DIGEST_LANES - 1);

  function automatic lane_idx_t next_lane(input lane_idx_t lane);
    return lane + lane_idx_t'(1);
  endfunction
endpackage

// File: rtl/sha3_digest_fifo.sv
// DEPTH-entry FIFO of 256-bit digests with registered pointers and occupancy.
module sha3_digest_fifo
  import sha3_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  sha3_digest_t wdata_i,
  output sha3_digest_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  sha3_digest_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A write into a full FIFO is legal when the head leaves on the same edge.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/sha3_digest_out.sv
// Captures final-round Keccak states, buffers the 256-bit digests and streams them as 64-bit lanes.
module sha3_digest_out
  import sha3_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pushin,
  input  logic [ROUND_W-1:0] dix,
  input  sha3_state_t        din,
  input  logic               stopin,
  output logic               pushout,
  output logic [LANE_W-1:0]  dout,
  output logic               lastout,
  output logic               overflow
);
  sha3_digest_t cap_digest, head_digest;
  logic         capture, fifo_full, fifo_empty;
  logic         beat_accept, digest_pop;
  lane_idx_t    lane_q, lane_d;
  logic         overflow_q, overflow_d;
  logic         unused_inputs;

  assign capture = pushin & dix[FINAL_ROUND_BIT];

  generate
    for (genvar gi = 0; gi < DIGEST_LANES; gi++) begin : g_lane
      assign cap_digest[gi] = din[gi][0];
    end
  endgenerate

  // Only row y=0 and the final-round flag matter; the rest of the state is folded away.
  assign unused_inputs = ^{din, dix};

  sha3_digest_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (capture),
    .pop_i   (digest_pop),
    .wdata_i (cap_digest),
    .rdata_o (head_digest),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pushout     = ~fifo_empty;
  assign lastout     = pushout & (lane_q == LAST_LANE);
  assign dout        = pushout ? head_digest[lane_q] : '0;
  assign beat_accept = pushout & ~stopin;
  assign digest_pop  = beat_accept & lastout;
  assign overflow    = overflow_q;

  always_comb begin
    lane_d     = beat_accept ? next_lane(lane_q) : lane_q;
    overflow_d = overflow_q | (capture & fifo_full & ~digest_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_sha3_digest_out.sv
// Self-checking bench: constant vector table, directed corner sequences, randomized run vs a queue model.
module tb_sha3_digest_out;
  import sha3_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pushin = 1'b0;
  logic        stopin = 1'b0;
  logic [23:0] dix = '0;
  sha3_state_t din = '0;
  logic        pushout, lastout, overflow;
  logic [63:0] dout;

  sha3_digest_out #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .pushin   (pushin),
    .dix      (dix),
    .din      (din),
    .stopin   (stopin),
    .pushout  (pushout),
    .dout     (dout),
    .lastout  (lastout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;
  string phase  = "reset";

  // Reference model: queue of whole digests, index of the lane on display, sticky overflow.
  logic [255:0] mq[$];
  int           mlane = 0;
  bit           movf  = 1'b0;

  localparam logic [23:0] FINAL = 24'h800000;

  typedef struct {
    bit          push;
    logic [23:0] dx;
    bit          stop;
    bit          e_po;
    logic [63:0] e_d;
    bit          e_lo;
    bit          e_ov;
  } vec_t;

  function automatic logic [63:0] lane_of(input logic [255:0] dg, input int i);
    return dg[i*64 +: 64];
  endfunction

  function automatic sha3_state_t mk_state(input logic [255:0] dg);
    sha3_state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) s[i][0] = dg[i*64 +: 64];
    return s;
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    mlane = 0;
    movf  = 1'b0;
  endtask

  task automatic model_update(input bit p, input logic [23:0] dx, input sha3_state_t d, input bit s);
    bit acc, pop, cap;
    logic [255:0] dg;
    if (reset) begin
      model_reset();
      return;
    end
    acc = (mq.size() != 0) && !s;
    pop = acc && (mlane == 3);
    cap = p && dx[23];
    for (int i = 0; i < 4; i++) dg[i*64 +: 64] = d[i][0];
    if (acc) mlane = (mlane + 1) % 4;
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (mq.size() < DEPTH) mq.push_back(dg);
      else movf = 1'b1;
    end
  endtask

  task automatic model_check();
    bit          e_po, e_lo;
    logic [63:0] e_d;
    e_po = (mq.size() != 0);
    e_d  = e_po ? lane_of(mq[0], mlane) : 64'h0;
    e_lo = e_po && (mlane == 3);
    checks++;
    if (pushout !== e_po || dout !== e_d || lastout !== e_lo || overflow !== movf) begin
      errors++;
      $display("FAIL model[%s] t=%0t: got po=%0b dout=%h last=%0b ovf=%0b, expected po=%0b dout=%h last=%0b ovf=%0b",
               phase, $time, pushout, dout, lastout, overflow, e_po, e_d, e_lo, movf);
    end
  endtask

  task automatic expect_out(input string name, input bit po, input logic [63:0] d, input bit lo, input bit ov);
    checks++;
    if (pushout !== po || dout !== d || lastout !== lo || overflow !== ov) begin
      errors++;
      $display("FAIL %s t=%0t: got po=%0b dout=%h last=%0b ovf=%0b, expected po=%0b dout=%h last=%0b ovf=%0b",
               name, $time, pushout, dout, lastout, overflow, po, d, lo, ov);
    end
  endtask

  // One clock: drive at the negedge, let the model follow the posedge, compare at the next negedge.
  task automatic step(input bit p, input logic [23:0] dx, input sha3_state_t d, input bit s);
    pushin = p;
    dix    = dx;
    din    = d;
    stopin = s;
    if (pushout && !s && !reset) beats++;
    @(posedge clk);
    model_update(p, dx, d, s);
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'h0, mk_state(rand_digest()), 1'b0);
  endtask

  logic [255:0] dg_a, dg_b, dg_c, dg_d;
  vec_t         tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dg_a = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    dg_b = {64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555};
    dg_c = {64'hdddddddddddddddd, 64'hcccccccccccccccc, 64'hbbbbbbbbbbbbbbbb, 64'haaaaaaaaaaaaaaaa};
    dg_d = {64'h0d0d0d0d0d0d0d0d, 64'h0c0c0c0c0c0c0c0c, 64'h0b0b0b0b0b0b0b0b, 64'h0a0a0a0a0a0a0a0a};

    tbl[0] = '{1'b1, FINAL,    1'b0, 1'b1, 64'h1111111111111111, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 24'h0,    1'b0, 1'b1, 64'h2222222222222222, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 24'h0,    1'b0, 1'b1, 64'h3333333333333333, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 24'h0,    1'b0, 1'b1, 64'h4444444444444444, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 24'h0,    1'b0, 1'b0, 64'h0,                1'b0, 1'b0};
    tbl[5] = '{1'b1, 24'h400000, 1'b0, 1'b0, 64'h0,              1'b0, 1'b0};
    tbl[6] = '{1'b1, 24'h000001, 1'b1, 1'b0, 64'h0,              1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    step(1'b0, 24'h0, '0, 1'b0);
    step(1'b1, FINAL, mk_state(dg_a), 1'b0);
    expect_out("reset_state", 1'b0, 64'h0, 1'b0, 1'b0);
    reset = 1'b0;

    // Single digest from the constant table
    phase = "table";
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].push, tbl[i].dx, mk_state(dg_a), tbl[i].stop);
      expect_out($sformatf("vec%0d", i), tbl[i].e_po, tbl[i].e_d, tbl[i].e_lo, tbl[i].e_ov);
    end

    // Non-final rounds never produce output
    phase = "nonfinal";
    for (int r = 0; r < 23; r++) begin
      step(1'b1, 24'h1 << r, mk_state(rand_digest()), 1'b0);
      expect_out($sformatf("nonfinal_r%0d", r), 1'b0, 64'h0, 1'b0, 1'b0);
    end

    // Stall on beat 2 holds the output
    phase = "stall";
    step(1'b1, FINAL, mk_state(dg_a), 1'b0);
    step(1'b0, 24'h0, mk_state(dg_b), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 24'h0, mk_state(dg_b), 1'b1);
      expect_out("stall_hold", 1'b1, 64'h2222222222222222, 1'b0, 1'b0);
    end
    step(1'b0, 24'h0, mk_state(dg_b), 1'b0);
    expect_out("stall_b3", 1'b1, 64'h3333333333333333, 1'b0, 1'b0);
    step(1'b0, 24'h0, mk_state(dg_b), 1'b0);
    expect_out("stall_b4", 1'b1, 64'h4444444444444444, 1'b1, 1'b0);
    idle(2);

    // Full buffer: capture on the same edge as the final accepted beat
    phase = "full_pop";
    step(1'b1, FINAL, mk_state(dg_a), 1'b1);
    step(1'b1, FINAL, mk_state(dg_b), 1'b1);
    idle(3);
    expect_out("full_pop_last", 1'b1, lane_of(dg_a, 3), 1'b1, 1'b0);
    step(1'b1, FINAL, mk_state(dg_c), 1'b0);
    expect_out("full_pop_next", 1'b1, lane_of(dg_b, 0), 1'b0, 1'b0);
    idle(4);
    expect_out("full_pop_third", 1'b1, lane_of(dg_c, 0), 1'b0, 1'b0);
    idle(5);

    // Overflow: third capture into a stalled full buffer is dropped
    phase = "overflow";
    step(1'b1, FINAL, mk_state(dg_a), 1'b1);
    step(1'b1, FINAL, mk_state(dg_b), 1'b1);
    expect_out("ovf_before", 1'b1, lane_of(dg_a, 0), 1'b0, 1'b0);
    step(1'b1, FINAL, mk_state(dg_c), 1'b1);
    expect_out("ovf_set", 1'b1, lane_of(dg_a, 0), 1'b0, 1'b1);
    beats = 0;
    idle(12);
    checks++;
    if (beats != 8) begin
      errors++;
      $display("FAIL ovf_beats: got %0d beats, expected 8", beats);
    end
    expect_out("ovf_sticky", 1'b0, 64'h0, 1'b0, 1'b1);

    // Reset in the middle of a digest
    phase = "reset_mid";
    step(1'b1, FINAL, mk_state(dg_d), 1'b0);
    idle(2);
    expect_out("pre_reset", 1'b1, lane_of(dg_d, 2), 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    expect_out("reset_async", 1'b0, 64'h0, 1'b0, 1'b0);
    model_reset();
    step(1'b0, 24'h0, mk_state(dg_d), 1'b0);
    step(1'b1, FINAL, mk_state(dg_d), 1'b0);
    reset = 1'b0;
    beats = 0;
    idle(6);
    checks++;
    if (beats != 0) begin
      errors++;
      $display("FAIL reset_no_resume: got %0d beats, expected 0", beats);
    end
    step(1'b1, FINAL, mk_state(dg_c), 1'b0);
    expect_out("after_reset_capture", 1'b1, lane_of(dg_c, 0), 1'b0, 1'b0);
    idle(5);

    // Randomized traffic against the model
    phase = "random";
    for (int n = 0; n < 500; n++) begin
      bit          p, s;
      logic [23:0] dx;
      p     = ($urandom_range(0, 99) < 35);
      s     = ($urandom_range(0, 99) < 30);
      dx    = ($urandom_range(0, 1) == 1) ? FINAL : (24'h1 << $urandom_range(0, 22));
      reset = ($urandom_range(0, 199) == 0);
      step(p, dx, mk_state(rand_digest()), s);
    end
    reset = 1'b0;
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
